// File: rtl/nfc_copy_sched.sv
// nfc_copy_sched: round-robin scheduler that runs {page, count} copy jobs on the flash page-copy engine.
// Define NFC_RETRY_EN to retry each failed page up to MAX_RETRY times before the job is aborted.
module nfc_copy_sched #(
    parameter int PAGE_W    = 9,
    parameter int CNT_W     = 10,
    parameter int MAX_RETRY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [PAGE_W-1:0] req0_page,
    input  logic [CNT_W-1:0]  req0_cnt,
    output logic              req0_done,
    output logic              req0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [PAGE_W-1:0] req1_page,
    input  logic [CNT_W-1:0]  req1_cnt,
    output logic              req1_done,
    output logic              req1_err,
    output logic              cp_start,
    output logic [PAGE_W-1:0] cp_page,
    input  logic              cp_done,
    input  logic              cp_fail,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'({1'b1, {PAGE_W{1'b0}}});
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);
    localparam logic [PAGE_W-1:0] PAGE_ONE = PAGE_W'(1'b1);

`ifdef NFC_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1'b1);
`endif

    state_t              state_r;
    state_t              state_nx_s;
    logic [PAGE_W-1:0]   page_r;
    logic [PAGE_W-1:0]   page_nx_s;
    logic [CNT_W-1:0]    remain_r;
    logic [CNT_W-1:0]    remain_nx_s;
    logic                owner_r;
    logic                owner_nx_s;
    logic                err_r;
    logic                err_nx_s;
    logic                ptr_r;
    logic                ptr_nx_s;
    logic                grant_s;
    logic                grant_vld_s;
    logic                accept_s;
    logic                cp_start_r;
    logic                done0_r;
    logic                done1_r;
    logic                err0_r;
    logic                err1_r;
    logic                busy_r;
`ifdef NFC_RETRY_EN
    logic [RETRY_W-1:0]  retry_r;
    logic [RETRY_W-1:0]  retry_nx_s;
`endif

    function automatic logic [CNT_W-1:0] clip_cnt(input logic [CNT_W-1:0] cnt);
        if (cnt > MAX_CNT) begin
            clip_cnt = MAX_CNT;
        end else begin
            clip_cnt = cnt;
        end
    endfunction

    // Round-robin winner: sole valid requester, or the pointer on a tie
    always_comb begin
        grant_s     = 1'b0;
        grant_vld_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s     = ptr_r;
            grant_vld_s = 1'b1;
        end else if (req0_valid) begin
            grant_s     = 1'b0;
            grant_vld_s = 1'b1;
        end else if (req1_valid) begin
            grant_s     = 1'b1;
            grant_vld_s = 1'b1;
        end else begin
            grant_s     = 1'b0;
            grant_vld_s = 1'b0;
        end
    end

    assign accept_s   = grant_vld_s && (state_r == ST_IDLE) && !rst;
    assign req0_ready = accept_s && !grant_s;
    assign req1_ready = accept_s && grant_s;

    // Next-state and job datapath update
    always_comb begin
        state_nx_s  = state_r;
        page_nx_s   = page_r;
        remain_nx_s = remain_r;
        owner_nx_s  = owner_r;
        err_nx_s    = err_r;
        ptr_nx_s    = ptr_r;
`ifdef NFC_RETRY_EN
        retry_nx_s  = retry_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s  = ST_ISSUE;
                    page_nx_s   = grant_s ? req1_page : req0_page;
                    remain_nx_s = clip_cnt(grant_s ? req1_cnt : req0_cnt);
                    owner_nx_s  = grant_s;
                    err_nx_s    = 1'b0;
`ifdef NFC_RETRY_EN
                    retry_nx_s  = {RETRY_W{1'b0}};
`endif
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // A zero-count job passes through ISSUE without a start pulse
                if (remain_r == CNT_ZERO) begin
                    state_nx_s = ST_FIN;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cp_done && !cp_fail) begin
                    state_nx_s = ST_NEXT;
`ifdef NFC_RETRY_EN
                    retry_nx_s = {RETRY_W{1'b0}};
`endif
                end else if (cp_done) begin
`ifdef NFC_RETRY_EN
                    if (retry_r < RETRY_MAX) begin
                        retry_nx_s = retry_r + RETRY_ONE;
                        state_nx_s = ST_ISSUE;
                    end else begin
                        err_nx_s   = 1'b1;
                        state_nx_s = ST_FIN;
                    end
`else
                    err_nx_s   = 1'b1;
                    state_nx_s = ST_FIN;
`endif
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_NEXT: begin
                page_nx_s   = page_r + PAGE_ONE;
                remain_nx_s = remain_r - CNT_ONE;
                if (remain_r == CNT_ONE) begin
                    state_nx_s = ST_FIN;
                end else begin
                    state_nx_s = ST_ISSUE;
                end
            end
            ST_FIN: begin
                ptr_nx_s   = ~owner_r;
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Job context registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            page_r   <= {PAGE_W{1'b0}};
            remain_r <= CNT_ZERO;
            owner_r  <= 1'b0;
            err_r    <= 1'b0;
            ptr_r    <= 1'b0;
`ifdef NFC_RETRY_EN
            retry_r  <= {RETRY_W{1'b0}};
`endif
        end else begin
            page_r   <= page_nx_s;
            remain_r <= remain_nx_s;
            owner_r  <= owner_nx_s;
            err_r    <= err_nx_s;
            ptr_r    <= ptr_nx_s;
`ifdef NFC_RETRY_EN
            retry_r  <= retry_nx_s;
`endif
        end
    end

    // Output flops are loaded from next-state so pulses line up with the state they belong to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cp_start_r <= 1'b0;
            done0_r    <= 1'b0;
            done1_r    <= 1'b0;
            err0_r     <= 1'b0;
            err1_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            cp_start_r <= (state_nx_s == ST_ISSUE) && (remain_nx_s != CNT_ZERO);
            done0_r    <= (state_nx_s == ST_FIN) && !owner_nx_s;
            done1_r    <= (state_nx_s == ST_FIN) && owner_nx_s;
            busy_r     <= (state_nx_s != ST_IDLE);
            if ((state_nx_s == ST_FIN) && !owner_nx_s) begin
                err0_r <= err_nx_s;
            end
            if ((state_nx_s == ST_FIN) && owner_nx_s) begin
                err1_r <= err_nx_s;
            end
        end
    end

    assign cp_start  = cp_start_r;
    assign cp_page   = page_r;
    assign req0_done = done0_r;
    assign req1_done = done1_r;
    assign req0_err  = err0_r;
    assign req1_err  = err1_r;
    assign busy      = busy_r;
    assign owner     = owner_r;

endmodule

// File: tb/tb_nfc_copy_sched.sv
// Directed self-checking bench for nfc_copy_sched (default build, NFC_RETRY_EN undefined).
module tb_nfc_copy_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid;
    logic       req0_ready;
    logic [8:0] req0_page;
    logic [9:0] req0_cnt;
    logic       req0_done;
    logic       req0_err;
    logic       req1_valid;
    logic       req1_ready;
    logic [8:0] req1_page;
    logic [9:0] req1_cnt;
    logic       req1_done;
    logic       req1_err;
    logic       cp_start;
    logic [8:0] cp_page;
    logic       cp_done;
    logic       cp_fail;
    logic       busy;
    logic       owner;

    int n_assert = 0;
    int n_fail   = 0;

    nfc_copy_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_page  (req0_page),
        .req0_cnt   (req0_cnt),
        .req0_done  (req0_done),
        .req0_err   (req0_err),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_page  (req1_page),
        .req1_cnt   (req1_cnt),
        .req1_done  (req1_done),
        .req1_err   (req1_err),
        .cp_start   (cp_start),
        .cp_page    (cp_page),
        .cp_done    (cp_done),
        .cp_fail    (cp_fail),
        .busy       (busy),
        .owner      (owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_r0rdy"}, req0_ready, 1'b0);
        chk({tag, "_r1rdy"}, req1_ready, 1'b0);
        chk({tag, "_r0done"}, req0_done, 1'b0);
        chk({tag, "_r1done"}, req1_done, 1'b0);
        chk({tag, "_r0err"}, req0_err, 1'b0);
        chk({tag, "_r1err"}, req1_err, 1'b0);
        chk({tag, "_start"}, cp_start, 1'b0);
        chk({tag, "_page"}, cp_page, 9'd0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_owner"}, owner, 1'b0);
    endtask

    // Called at a negedge in IDLE; the job is accepted on the following posedge.
    task automatic submit(input int r, input logic [8:0] page, input logic [9:0] cnt);
        if (r == 0) begin
            req0_valid = 1'b1; req0_page = page; req0_cnt = cnt;
        end else begin
            req1_valid = 1'b1; req1_page = page; req1_cnt = cnt;
        end
        #1;
        chk("ready_winner", r ? req1_ready : req0_ready, 1'b1);
        chk("ready_loser", r ? req0_ready : req1_ready, 1'b0);
        @(negedge clk);
        if (r == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    // Called at the negedge one cycle after accept; plays the engine and checks the job to its end.
    task automatic serve(input int r, input logic [8:0] page, input int npages, input int fail_at, input int gap);
        logic [8:0] p;
        logic [8:0] step;
        if (npages == 0) begin
            chk("zero_no_start", cp_start, 1'b0);
            @(negedge clk);
        end
        for (int i = 0; i < npages; i++) begin
            step = 9'(i);
            p    = page + step;
            chk("cp_start", cp_start, 1'b1);
            chk("cp_page", cp_page, p);
            chk("busy_mid", busy, 1'b1);
            repeat (gap) @(negedge clk);
            chk("start_one_cycle", cp_start, 1'b0);
            chk("cp_page_hold", cp_page, p);
            cp_done = 1'b1;
            cp_fail = (i == fail_at);
            @(negedge clk);
            cp_done = 1'b0;
            cp_fail = 1'b0;
            if (i == fail_at) break;
            @(negedge clk);
        end
        chk("done_owner", r ? req1_done : req0_done, 1'b1);
        chk("done_other", r ? req0_done : req1_done, 1'b0);
        chk("done_err", r ? req1_err : req0_err, fail_at >= 0);
        chk("no_start_at_done", cp_start, 1'b0);
        chk("owner", owner, r[0]);
        chk("busy_at_done", busy, 1'b1);
        @(negedge clk);
        chk("done_one_cycle", r ? req1_done : req0_done, 1'b0);
        chk("busy_clear", busy, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_page  = 9'd0;
        req0_cnt   = 10'd1;
        req1_valid = 1'b0;
        req1_page  = 9'd0;
        req1_cnt   = 10'd0;
        cp_done    = 1'b0;
        cp_fail    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        req0_valid = 1'b0;
        rst        = 1'b0;
        @(negedge clk);

        // Basic 3-page job, engine answers 4 cycles after each start
        submit(0, 9'd5, 10'd3);
        serve(0, 9'd5, 3, -1, 4);

        // Re-reset so the round-robin pointer starts at requester 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Simultaneous requests: 0, then 1, then 0 again
        req0_valid = 1'b1; req0_page = 9'd40; req0_cnt = 10'd1;
        req1_valid = 1'b1; req1_page = 9'd60; req1_cnt = 10'd1;
        #1;
        chk("arb_tie_r0", req0_ready, 1'b1);
        chk("arb_tie_r1", req1_ready, 1'b0);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("no_ready_busy", req1_ready, 1'b0);
        serve(0, 9'd40, 1, -1, 2);
        #1;
        chk("arb_rr_r1", req1_ready, 1'b1);
        chk("arb_rr_r0", req0_ready, 1'b0);
        @(negedge clk);
        req1_valid = 1'b0;
        serve(1, 9'd60, 1, -1, 2);
        req0_valid = 1'b1; req0_page = 9'd80;
        req1_valid = 1'b1; req1_page = 9'd90;
        #1;
        chk("arb_alt_r0", req0_ready, 1'b1);
        chk("arb_alt_r1", req1_ready, 1'b0);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        serve(0, 9'd80, 1, -1, 2);

        // Page index wraps 511 -> 0
        submit(1, 9'd510, 10'd4);
        serve(1, 9'd510, 4, -1, 3);

        // Zero-count job
        submit(0, 9'd33, 10'd0);
        serve(0, 9'd33, 0, -1, 0);

        // Failure on the second page aborts the job
        submit(1, 9'd20, 10'd3);
        serve(1, 9'd20, 3, 1, 3);

        // Error flag of requester 1 survives a job of requester 0
        submit(0, 9'd50, 10'd0);
        serve(0, 9'd50, 0, -1, 0);
        chk("err_hold_r1", req1_err, 1'b1);
        chk("err_r0_clean", req0_err, 1'b0);

        // Count above 512 is clipped to a full sweep of the page space
        submit(0, 9'd0, 10'd700);
        serve(0, 9'd0, 512, -1, 1);

        // Reset while waiting on page 100
        submit(0, 9'd100, 10'd2);
        chk("rst_case_page", cp_page, 9'd100);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst     = 1'b0;
        cp_done = 1'b1;
        @(negedge clk);
        cp_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("post_rst_r0done", req0_done, 1'b0);
            chk("post_rst_r1done", req1_done, 1'b0);
            chk("post_rst_start", cp_start, 1'b0);
            chk("post_rst_busy", busy, 1'b0);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
